// File: rtl/TEST_TYPES.sv
// Shared test types used by the array producer and its consumers.
//   a_struct_t : one array element; a single 'stuff' bit.
package TEST_TYPES;
  typedef struct packed {
    logic stuff;
  } a_struct_t;
endpackage

// File: rtl/struct_chk_pkg.sv
// Checker-side shared definitions.
//   chk_state_e    : run FSM states.
//   expected_stuff : golden alternating pattern, element i holds bit 0 of i.
package struct_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_e;

  function automatic logic expected_stuff(input int i);
    return i[0];
  endfunction
endpackage

// File: rtl/struct_array_cmp.sv
// Registered compare stage: per-element mismatch of an accepted beat
// against the golden pattern.
// Ports:
//   clk, rst          : clock, async active-high reset
//   beat / beat_vld   : accepted array beat (N elements) and its valid
//   mismatch / mm_vld : registered per-element mismatch and its valid
module struct_array_cmp #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] beat,
  input  logic         beat_vld,
  output logic [N-1:0] mismatch,
  output logic         mm_vld
);
  import TEST_TYPES::*;
  import struct_chk_pkg::*;

  a_struct_t [N-1:0] elem;
  logic      [N-1:0] mm_d;

  assign elem = beat;

  for (genvar g = 0; g < N; g++) begin : g_elem
    assign mm_d[g] = elem[g].stuff ^ expected_stuff(g);
  end

  // Reset also drops any beat in flight so an aborted run leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= '0;
      mm_vld   <= 1'b0;
    end else begin
      mm_vld <= beat_vld;
      if (beat_vld) mismatch <= mm_d;
    end
  end
endmodule

// File: rtl/struct_array_checker.sv
// Clocked checker for the packed a_struct_t array stream. Accepts
// NUM_SAMPLES beats over valid/ready, compares each against the alternating
// golden pattern, and reports saturating pass/fail counts, the mismatch mask
// of the first failing beat, and a done/pass verdict.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   start                     : begin a run from IDLE or DONE
//   in_valid/in_ready/in_data : beat handshake and N-bit array beat
//   pass_cnt, fail_cnt        : saturating beat counters (CNT_W bits)
//   first_fail_mask           : mismatch mask of the first failing beat
//   done, pass                : run complete; pass = no failing beat
module struct_array_checker #(
  parameter int N           = 4,
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [N-1:0]     first_fail_mask,
  output logic             done,
  output logic             pass
);
  import struct_chk_pkg::*;

  localparam int            BW = $clog2(NUM_SAMPLES + 1);
  localparam logic [BW-1:0] NS = BW'(NUM_SAMPLES);

  chk_state_e    state, state_nxt;
  logic [BW-1:0] beat_cnt;
  logic          accept;
  logic          clr;
  logic [N-1:0]  mismatch;
  logic          mm_vld;

  assign accept = in_valid && in_ready;
  // start only matters outside RUN; it clears the run state on that edge.
  assign clr    = (state != RUN) && start;
  assign pass   = done && (fail_cnt == '0);

  struct_array_cmp #(.N(N)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .beat     (in_data),
    .beat_vld (accept),
    .mismatch (mismatch),
    .mm_vld   (mm_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        in_ready = (beat_cnt < NS);
        // Beats retire in order one cycle after acceptance, so the last
        // beat being counted means nothing else is in flight.
        if (mm_vld && (beat_cnt == NS)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt        <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_mask <= '0;
    end else if (clr) begin
      beat_cnt        <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_mask <= '0;
    end else begin
      if (accept) beat_cnt <= beat_cnt + 1'b1;
      if (mm_vld) begin
        if (|mismatch) begin
          // fail_cnt saturates and never returns to zero within a run,
          // so zero identifies the first failing beat.
          if (fail_cnt == '0) first_fail_mask <= mismatch;
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end else if (pass_cnt != '1) begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_struct_array_checker.sv
module tb_struct_array_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, done, pass;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] first_fail_mask;

  logic       s_start = 1'b0, s_valid = 1'b0;
  logic [3:0] s_data = 4'b1010;
  logic       s_ready, s_done, s_pass;
  logic [1:0] s_pass_cnt, s_fail_cnt;
  logic [3:0] s_mask;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  struct_array_checker #(.N(4), .NUM_SAMPLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .first_fail_mask(first_fail_mask),
    .done(done), .pass(pass)
  );

  struct_array_checker #(.N(4), .NUM_SAMPLES(6), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid),
    .in_ready(s_ready), .in_data(s_data), .pass_cnt(s_pass_cnt),
    .fail_cnt(s_fail_cnt), .first_fail_mask(s_mask),
    .done(s_done), .pass(s_pass)
  );

  typedef struct {
    string            name;
    logic [7:0][3:0]  beats;
    bit               gap;
    logic [7:0]       exp_pass;
    logic [7:0]       exp_fail;
    logic [3:0]       exp_mask;
    logic             exp_verdict;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // start is raised together with a bad beat; that beat must not be taken.
  task automatic pulse_start(input string name);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk({name, ".ready_after_start"}, in_ready, 1);
    chk({name, ".done_cleared"}, done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int idx = 0;
    int cyc = 0;
    logic acc;
    pulse_start(v.name);
    while (idx < 8 && cyc < 100) begin
      @(negedge clk);
      in_valid = !v.gap || (cyc % 2 == 0);
      in_data  = v.beats[idx];
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    chk({v.name, ".accepted"}, idx, 8);
    @(negedge clk);
    in_valid = 1'b0;
    chk({v.name, ".ready_low"}, in_ready, 0);
    chk({v.name, ".done_not_yet"}, done, 0);
    @(negedge clk);
    chk({v.name, ".done"}, done, 1);
    chk({v.name, ".pass_cnt"}, pass_cnt, v.exp_pass);
    chk({v.name, ".fail_cnt"}, fail_cnt, v.exp_fail);
    chk({v.name, ".mask"}, first_fail_mask, v.exp_mask);
    chk({v.name, ".pass"}, pass, v.exp_verdict);
  endtask

  initial begin
    // beats[i] is the i-th beat sent; golden is 4'b1010.
    vecs[0] = '{"all_ok", {8{4'b1010}}, 1'b0, 8'd8, 8'd0, 4'b0000, 1'b1};
    vecs[1] = '{"two_bad", {4'b1010, 4'b1010, 4'b0010, 4'b1010, 4'b1011,
                            4'b1010, 4'b1010, 4'b1010},
                1'b0, 8'd6, 8'd2, 4'b0001, 1'b0};
    vecs[2] = '{"gapped", {8{4'b1010}}, 1'b1, 8'd8, 8'd0, 4'b0000, 1'b1};
    vecs[3] = '{"first_all_bad", {{7{4'b1010}}, 4'b0101},
                1'b0, 8'd7, 8'd1, 4'b1111, 1'b0};
    vecs[4] = '{"late_bad", {4'b0000, 4'b1110, {6{4'b1010}}},
                1'b1, 8'd6, 8'd2, 4'b0100, 1'b0};

    #12;
    chk("rst.ready", in_ready, 0);
    chk("rst.pass_cnt", pass_cnt, 0);
    chk("rst.fail_cnt", fail_cnt, 0);
    chk("rst.mask", first_fail_mask, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;

    // valid in IDLE without start is ignored
    in_valid = 1'b1; in_data = 4'b0101;
    repeat (4) @(negedge clk);
    chk("idle.ready", in_ready, 0);
    chk("idle.pass_cnt", pass_cnt, 0);
    chk("idle.fail_cnt", fail_cnt, 0);
    in_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // valid in DONE without start is ignored
    in_valid = 1'b1; in_data = 4'b0101;
    repeat (4) @(negedge clk);
    chk("done_idle.ready", in_ready, 0);
    chk("done_idle.done", done, 1);
    chk("done_idle.pass_cnt", pass_cnt, 6);
    chk("done_idle.fail_cnt", fail_cnt, 2);
    in_valid = 1'b0;

    // reset after the 4th beat, with that beat still in flight
    pulse_start("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (i == 3) ? 4'b0101 : 4'b1010;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort.ready", in_ready, 0);
    chk("abort.pass_cnt", pass_cnt, 0);
    chk("abort.fail_cnt", fail_cnt, 0);
    chk("abort.mask", first_fail_mask, 0);
    chk("abort.done", done, 0);
    chk("abort.pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0]);

    // saturation: 6 good beats into 2-bit counters
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_valid = 1'b1; s_data = 4'b1010;
    begin
      int cyc = 0;
      while (!s_done && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("sat.done", s_done, 1);
    end
    s_valid = 1'b0;
    chk("sat.pass_cnt", s_pass_cnt, 3);
    chk("sat.fail_cnt", s_fail_cnt, 0);
    chk("sat.mask", s_mask, 0);
    chk("sat.pass", s_pass, 1);
    chk("sat.ready", s_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/struct_array_checker.md
# struct_array_checker

Downstream consumer of the packed `TEST_TYPES::a_struct_t [N-1:0]` array driven by the array-producing stage. It accepts array beats over a valid/ready handshake and compares each element against the golden alternating pattern (element i `stuff` == bit 0 of i). It counts passing and failing beats and reports a sticky first-failure mask and a final pass/done verdict. It sits between the array producer and the testbench top, replacing ad-hoc per-element `$stop` checks with a clocked, self-counting checker.

## Interface
- `N`, 4, number of array elements; must be ≥1.
- `NUM_SAMPLES`, 8, beats to check per run; must be ≥1.
- `CNT_W`, 8, width of pass/fail counters.
- `clk`  input  1  sole clock; all state updates on posedge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  pulse; begins a run from IDLE or DONE.
- `in_valid`  input  1  upstream beat valid.
- `in_ready`  output  1  checker accepts a beat this cycle.
- `in_data`  input  N×`a_struct_t` (N bits)  array beat.
- `pass_cnt`  output  CNT_W  beats fully matching the pattern.
- `fail_cnt`  output  CNT_W  beats with ≥1 mismatching element.
- `first_fail_mask`  output  N  per-element mismatch mask of the first failing beat in the run.
- `done`  output  1  run complete.
- `pass`  output  1  valid while `done`; 1 iff `fail_cnt`==0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `in_ready`=0. `start`=1 moves to RUN and clears counters, mask, and the accepted-beat counter.
- RUN: `in_ready`=1 while the accepted-beat count is < NUM_SAMPLES. A beat is accepted when `in_valid && in_ready`. `start` is ignored.
- Stage 1 captures accepted `in_data` and a valid bit.
- Stage 2 (next edge) computes `mismatch[i] = in_data[i].stuff ^ i[0]`:
  - any bit set: `fail_cnt`+1; if it is the first failing beat of the run, latch `mismatch` into `first_fail_mask`.
  - otherwise: `pass_cnt`+1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- After NUM_SAMPLES beats are accepted, `in_ready` drops. The FSM moves to DONE on the edge the last beat is counted.
- DONE: `done`=1, `pass`=(`fail_cnt`==0), `in_ready`=0. Outputs hold. `start` moves to RUN with everything cleared.
- `in_valid` in IDLE/DONE is ignored; no beat is accepted.
- If `start` and `in_valid` are both high in IDLE, only `start` takes effect; the first beat can be accepted the following cycle.
- Reset asserted mid-run immediately aborts: all state clears, FSM returns to IDLE, and any in-flight stage-1 beat is discarded.

## Timing
- Reset values: `in_ready`=0, `pass_cnt`=0, `fail_cnt`=0, `first_fail_mask`=0, `done`=0, `pass`=0.
- `start` sampled at edge s: `in_ready`=1 from after edge s.
- Beat accepted at edge k: counters and mask update at edge k+1 (latency 1).
- Back-to-back acceptance every cycle is supported. Throughput is 1 beat/cycle.
- Last beat accepted at edge k: `in_ready`=0 after edge k; `done`=1 and final counts after edge k+1.
- `done` is a level, not a pulse. It deasserts on the edge that samples `start` in DONE.

## Structure
- Shared package `struct_chk_pkg` holds:
  - `chk_state_e` enum (IDLE/RUN/DONE);
  - the function `expected_stuff(int i)` returning `i[0]`.
- `a_struct_t` stays in `TEST_TYPES`.
- One sub-module, `struct_array_cmp`, is natural: the registered stage 2. It takes the stage-1 beat and valid and outputs a registered `mismatch[N-1:0]` plus a valid bit. The parent owns the FSM, handshake, and counters.

## Test plan
- Reset, then `start`, then 8 beats of pattern 4'b1010 (element 0 = 0) back-to-back → `pass_cnt`=8, `fail_cnt`=0, `done`=1, `pass`=1, `first_fail_mask`=0.
- Beats 3 and 5 set to 4'b1011 and 4'b0010, others correct → `fail_cnt`=2, `pass_cnt`=6, `first_fail_mask`=4'b0001, `pass`=0.
- `in_valid` toggled every other cycle → `done` rises exactly one cycle after the 8th accepted beat; `in_ready`=0 after the 8th acceptance.
- `in_valid`=1 in IDLE and DONE with no `start` → no counter change, `in_ready`=0.
- Reset asserted after the 4th beat in RUN → all outputs return to reset values asynchronously. A new `start` followed by 8 correct beats → `pass_cnt`=8.
- `CNT_W`=2 with `NUM_SAMPLES`=6, all correct → `pass_cnt` saturates at 3, `pass`=1.
